// File: rtl/ts4231_cfg_ctrl.sv
// TS4231 configuration sequencer: writes a 15-bit word over the open-drain E/D pair.
// Define TS4231_CFG_READBACK_EN to add the read-back frame, compare and retry logic.
module ts4231_cfg_ctrl #(
  parameter int unsigned HALF      = 8,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] cfg_word,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [14:0] readback,
  output logic        e_drive_low,
  output logic        d_drive_low,
  input  logic        e_in,
  input  logic        d_in
);

  localparam int unsigned PW = 6;
  localparam int unsigned TW = 8;
  localparam int unsigned WW = 15;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WR    = 3'd1;
  localparam logic [2:0] ST_DONE  = 3'd4;
`ifdef TS4231_CFG_READBACK_EN
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
`endif

  localparam logic [PW-1:0] PH_S1   = 6'd0;
  localparam logic [PW-1:0] PH_S2   = 6'd1;
  localparam logic [PW-1:0] PH_P1   = 6'd32;
  localparam logic [PW-1:0] PH_P2   = 6'd33;
  localparam logic [PW-1:0] PH_LAST = 6'd34;

  if (HALF < 2 || HALF > 255 || MAX_RETRY > 7) begin : g_param_check
    $error("ts4231_cfg_ctrl: HALF must be 2..255 and MAX_RETRY 0..7");
  end

  logic [2:0]    state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [WW-1:0] word, word_nxt;
  logic          pass, pass_nxt;
  logic          busy_nxt, done_nxt, ok_nxt, e_nxt, d_nxt;
  logic [WW-1:0] readback_nxt;
  logic [1:0]    e_sync, d_sync;
  logic          e_s, d_s;
  logic          phase_end;
  logic [4:0]    rel;
  logic [3:0]    bidx;
`ifdef TS4231_CFG_READBACK_EN
  logic [2:0]    retry, retry_nxt;
  logic [WW-1:0] shift, shift_nxt;
`endif

  assign e_s       = e_sync[1];
  assign d_s       = d_sync[1];
  assign phase_end = (timer == TW'(HALF - 1));

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      phase       <= '0;
      timer       <= '0;
      word        <= '0;
      pass        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ok          <= 1'b0;
      readback    <= '0;
      e_drive_low <= 1'b0;
      d_drive_low <= 1'b0;
      e_sync      <= 2'b11;
      d_sync      <= 2'b11;
`ifdef TS4231_CFG_READBACK_EN
      retry       <= '0;
      shift       <= '0;
`endif
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      timer       <= timer_nxt;
      word        <= word_nxt;
      pass        <= pass_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      ok          <= ok_nxt;
      readback    <= readback_nxt;
      e_drive_low <= e_nxt;
      d_drive_low <= d_nxt;
      e_sync      <= {e_sync[0], e_in};
      d_sync      <= {d_sync[0], d_in};
`ifdef TS4231_CFG_READBACK_EN
      retry       <= retry_nxt;
      shift       <= shift_nxt;
`endif
    end
  end

  // Next-state, sequencing and pad drive decode
  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    timer_nxt    = timer;
    word_nxt     = word;
    pass_nxt     = pass;
    ok_nxt       = ok;
    readback_nxt = readback;
    e_nxt        = 1'b0;
    d_nxt        = 1'b0;
    rel          = '0;
    bidx         = '0;
`ifdef TS4231_CFG_READBACK_EN
    retry_nxt    = retry;
    shift_nxt    = shift;
`endif

    case (state)
      ST_IDLE: begin
        timer_nxt = '0;
        phase_nxt = '0;
        // done still high means the previous sequence just ended; ignore start
        if (start && !done) begin
          ok_nxt = 1'b0;
`ifdef TS4231_CFG_READBACK_EN
          retry_nxt = '0;
`endif
          if (!e_s || !d_s) begin
            pass_nxt  = 1'b0;
            state_nxt = ST_DONE;
          end else begin
            word_nxt  = cfg_word;
            state_nxt = ST_WR;
          end
        end
      end

      ST_WR: begin
        if (phase_end) begin
          timer_nxt = '0;
          if (phase == PH_LAST) begin
            phase_nxt = '0;
`ifdef TS4231_CFG_READBACK_EN
            shift_nxt = '0;
            state_nxt = ST_RD;
`else
            pass_nxt  = 1'b1;
            state_nxt = ST_DONE;
`endif
          end else begin
            phase_nxt = phase + 6'd1;
          end
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end

`ifdef TS4231_CFG_READBACK_EN
      ST_RD: begin
        if (phase_end) begin
          timer_nxt = '0;
          // last cycle of a BHI phase: odd phases 3..31
          if (phase[0] && phase >= 6'd3 && phase <= 6'd31) begin
            shift_nxt = {shift[WW-2:0], d_s};
          end
          if (phase == PH_LAST) begin
            phase_nxt    = '0;
            readback_nxt = shift;
            state_nxt    = ST_CHECK;
          end else begin
            phase_nxt = phase + 6'd1;
          end
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end

      ST_CHECK: begin
        timer_nxt = '0;
        phase_nxt = '0;
        if (readback == word) begin
          pass_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end else if (retry < 3'(MAX_RETRY)) begin
          retry_nxt = retry + 3'd1;
          state_nxt = ST_WR;
        end else begin
          pass_nxt  = 1'b0;
          state_nxt = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        ok_nxt    = pass;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state == ST_DONE);

    // Drive levels follow the phase being entered so pads switch on phase boundaries
`ifdef TS4231_CFG_READBACK_EN
    if (state_nxt == ST_WR || state_nxt == ST_RD) begin
`else
    if (state_nxt == ST_WR) begin
`endif
      rel  = 5'(phase_nxt - 6'd2);
      bidx = 4'd14 - rel[4:1];
      case (phase_nxt)
        PH_S1:   d_nxt = 1'b1;
        PH_S2: begin
          e_nxt = 1'b1;
          d_nxt = 1'b1;
        end
        PH_P1: begin
          e_nxt = 1'b1;
          d_nxt = 1'b1;
        end
        PH_P2:   d_nxt = 1'b1;
        PH_LAST: d_nxt = 1'b0;
        default: begin
          e_nxt = ~rel[0];
          d_nxt = (state_nxt == ST_WR) & ~word_nxt[bidx];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts4231_cfg_ctrl.sv
// Scoreboard bench for ts4231_cfg_ctrl (HALF=4, MAX_RETRY=2); covers both
// TS4231_CFG_READBACK_EN builds.
module tb_ts4231_cfg_ctrl;

  localparam int unsigned H = 4;
  localparam int ATT = 70 * H + 1;
`ifdef TS4231_CFG_READBACK_EN
  localparam bit RB = 1'b1;
  localparam int LAT1 = 70 * H + 3;
`else
  localparam bit RB = 1'b0;
  localparam int LAT1 = 35 * H + 2;
`endif

  logic        clk, reset, start;
  logic [14:0] cfg_word;
  logic        busy, done, ok;
  logic [14:0] readback;
  logic        e_drive_low, d_drive_low;
  logic        e_in, d_in;
  logic        sensor_pull, e_hold_low, d_hold_low;

  ts4231_cfg_ctrl #(.HALF(H), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_word(cfg_word),
    .busy(busy), .done(done), .ok(ok), .readback(readback),
    .e_drive_low(e_drive_low), .d_drive_low(d_drive_low),
    .e_in(e_in), .d_in(d_in)
  );

  assign e_in = ~e_drive_low & ~e_hold_low;
  assign d_in = ~d_drive_low & ~d_hold_low & ~sensor_pull;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int t0; logic okv; logic [14:0] rb; int lat; } res_t;
  typedef struct { int t; logic [14:0] w; bit rd; } frm_t;
  res_t res_q[$];
  frm_t frm_q[$];

  // Sensor model: answers read frames by timing relative to the accepted start
  int          m_t0 = 0, m_natt = 0, m_mode = 0;
  logic [14:0] m_word = '0;
  bit          m_on = 1'b0;

  function automatic logic [14:0] sensor_word(input int k);
    if (m_mode == 1) return 15'h392A;
    if (m_mode == 2 && k == 0) return m_word ^ 15'h0001;
    return m_word;
  endfunction

  always @(negedge clk) begin : sensor_model
    int j, k, r, i;
    logic [14:0] w;
    sensor_pull = 1'b0;
    if (m_on && RB) begin
      j = cyc - m_t0;
      if (j >= 0) begin
        k = j / ATT;
        r = (j % ATT) - 35 * H;
        if (k < m_natt && r >= 2 * H && r < 32 * H) begin
          i = r / (2 * H) - 1;
          w = sensor_word(k);
          sensor_pull = ~w[14 - i];
        end
      end
    end
  end

  // Expected {e_drive_low,d_drive_low} per phase, phase 0 in the top bits
  function automatic logic [69:0] frame_exp(input logic [14:0] w, input bit rd);
    logic [69:0] v;
    logic e, d;
    v = '0;
    for (int p = 0; p < 35; p++) begin
      if (p == 0) begin e = 1'b0; d = 1'b1; end
      else if (p == 1) begin e = 1'b1; d = 1'b1; end
      else if (p == 32) begin e = 1'b1; d = 1'b1; end
      else if (p == 33) begin e = 1'b0; d = 1'b1; end
      else if (p == 34) begin e = 1'b0; d = 1'b0; end
      else begin
        e = ((p - 2) % 2 == 0);
        d = rd ? 1'b0 : ~w[14 - (p - 2) / 2];
      end
      v[2 * (34 - p) +: 2] = {e, d};
    end
    return v;
  endfunction

  logic [14:0] last_wr_dbits = '0;

  // Frame monitor: samples the pad drives mid-phase for each queued frame
  initial begin : frame_mon
    frm_t f;
    logic [69:0] act;
    logic [14:0] dbits;
    int tgt;
    forever begin
      @(negedge clk);
      if (frm_q.size() != 0) begin
        f = frm_q.pop_front();
        act = '0;
        dbits = '0;
        for (int p = 0; p < 35; p++) begin
          tgt = f.t + p * H + 1;
          while (cyc < tgt) @(negedge clk);
          act[2 * (34 - p) +: 2] = {e_drive_low, d_drive_low};
          if (p >= 2 && p <= 30 && (p % 2 == 0)) dbits[14 - (p - 2) / 2] = ~d_drive_low;
        end
        check(f.rd ? "read_frame" : "write_frame", act, frame_exp(f.w, f.rd));
        if (!f.rd) last_wr_dbits = dbits;
      end
    end
  end

  // Result monitor
  always @(negedge clk) begin : res_mon
    res_t e;
    if (!reset && done) begin
      if (res_q.size() == 0) begin
        check("unexpected_done", 70'(done), 70'(0));
      end else begin
        e = res_q.pop_front();
        check("ok", 70'(ok), 70'(e.okv));
        check("readback", 70'(readback), 70'(e.rb));
        check("latency", 70'(cyc - e.t0 + 1), 70'(e.lat));
      end
    end
  end

  bit watch = 1'b0, drove = 1'b0;
  always @(negedge clk) if (watch && (e_drive_low || d_drive_low)) drove = 1'b1;

  task automatic do_start(input logic [14:0] w, output int t0);
    @(negedge clk);
    cfg_word = w;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic run(input logic [14:0] w, input int mode, input int natt, input logic exp_ok,
                     input logic [14:0] exp_rb, input int exp_lat);
    int t0;
    res_t r;
    frm_t f;
    do_start(w, t0);
    r.t0 = t0; r.okv = exp_ok; r.rb = exp_rb; r.lat = exp_lat;
    res_q.push_back(r);
    for (int k = 0; k < natt; k++) begin
      f.t = t0 + k * ATT; f.w = w; f.rd = 1'b0;
      frm_q.push_back(f);
      if (RB) begin
        f.t = t0 + k * ATT + 35 * H; f.rd = 1'b1;
        frm_q.push_back(f);
      end
    end
    m_word = w; m_mode = mode; m_natt = natt; m_t0 = t0; m_on = 1'b1;
    for (int n = 0; n < exp_lat + 50 && res_q.size() != 0; n++) @(negedge clk);
    if (res_q.size() != 0) begin
      check("done_timeout", 70'(res_q.size()), 70'(0));
      res_q.delete();
    end
    m_on = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [14:0] last_rb;
  int t_abort;

  initial begin
    reset = 1'b1; start = 1'b0; cfg_word = '0;
    e_hold_low = 1'b0; d_hold_low = 1'b0; sensor_pull = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 70'({busy, done, ok, e_drive_low, d_drive_low, readback}), 70'(0));
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Echo of 392B; D waveform of the write frame is the word itself, MSB first
    run(15'h392B, 0, 1, 1'b1, RB ? 15'h392B : 15'h0, LAT1);
    check("wr_d_waveform", 70'(last_wr_dbits), 70'(15'b011100100101011));
    repeat (5) @(negedge clk);
    check("ok_held", 70'(ok), 70'(1));
    last_rb = RB ? 15'h392B : 15'h0;

`ifdef TS4231_CFG_READBACK_EN
    // Persistent mismatch: three attempts then failure
    run(15'h392B, 1, 3, 1'b0, 15'h392A, 2 * ATT + 70 * H + 3);
    // One mismatch then echo: two attempts
    run(15'h392B, 2, 2, 1'b1, 15'h392B, ATT + 70 * H + 3);
    last_rb = 15'h392B;
`endif

    // Bus held low on D, then on E: immediate failure, pads never driven
    d_hold_low = 1'b1; drove = 1'b0; watch = 1'b1;
    repeat (3) @(negedge clk);
    run(15'h1234, 0, 0, 1'b0, last_rb, 2);
    watch = 1'b0; d_hold_low = 1'b0;
    check("d_fault_pads_idle", 70'(drove), 70'(0));
    e_hold_low = 1'b1; drove = 1'b0; watch = 1'b1;
    repeat (3) @(negedge clk);
    run(15'h0F0F, 0, 0, 1'b0, last_rb, 2);
    watch = 1'b0; e_hold_low = 1'b0;
    check("e_fault_pads_idle", 70'(drove), 70'(0));
    repeat (3) @(negedge clk);

    // All-ones word with start pulses while busy that must not restart the frame
    fork
      run(15'h7FFF, 0, 1, 1'b1, RB ? 15'h7FFF : 15'h0, LAT1);
      begin
        repeat (50) @(negedge clk);
        cfg_word = 15'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join

    // All-zeros word
    run(15'h0000, 0, 1, 1'b1, 15'h0, LAT1);

    // Start pulse coincident with done is ignored
    fork
      run(15'h5555, 0, 1, 1'b1, RB ? 15'h5555 : 15'h0, LAT1);
      begin
        for (int n = 0; n < LAT1 + 20 && !done; n++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", 70'(busy), 70'(0));
      end
    join
    repeat (5) @(negedge clk);

    // Reset during BHI of bit 7 (D driven low there for 392B)
    do_start(15'h392B, t_abort);
    while (cyc < t_abort + 17 * H + 1) @(negedge clk);
    check("pre_reset_drive", 70'({busy, e_drive_low, d_drive_low}), 70'(3'b101));
    reset = 1'b1;
    @(negedge clk);
    check("reset_midframe", 70'({busy, done, e_drive_low, d_drive_low}), 70'(0));
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Normal operation after the abort
    run(15'h4C21, 0, 1, 1'b1, RB ? 15'h4C21 : 15'h0, LAT1);

    repeat (5) @(negedge clk);
    check("results_pending", 70'(res_q.size()), 70'(0));
    check("frames_pending", 70'(frm_q.size()), 70'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
